dp_task_dispatch: RTL
=====================

# dp_task_dispatch

Dispatch stage directly upstream of the reservation station. It buffers a list of edge-task packets, then replays that list once per iteration, issuing only the packets whose iteration-mask bit matches the current iteration. It issues into the RS under `RS_full` back-pressure, tracks outstanding tasks through Edge-PE completion pulses, and drives `replay_Iter` to the RS so RS arbitration and dispatch stay on the same iteration.

## Interface
Parameters:
- `PACKET_W`, 32 — RS packet width (`packet_size-2`); iteration mask occupies bits [9:7].
- `DEPTH`, 16 — task buffer entries.
- `NUM_PE`, 4 — Edge PE count (`Num_Edge_PE`).
- `ITER_W`, 2 — width of `replay_Iter` (`$clog2(Max_replay_Iter)`).

Ports:
- `clk` in 1 — clock. One clock; synchronous, active-high reset `reset`.
- `reset` in 1 — synchronous active-high reset.
- `task_in_valid` in 1 — load-side packet valid.
- `task_in_packet` in PACKET_W — packet to store.
- `task_in_ready` out 1 — buffer accepts a packet this cycle.
- `start` in 1 — one-cycle pulse; begins replay.
- `num_iter` in ITER_W — iterations to run, valid range 0..3, sampled on `start`.
- `RS_full` in 1 — RS next-state full flag.
- `pe_done` in NUM_PE — one-cycle completion pulse per PE.
- `DP_task2RS_out` out 1+PACKET_W — `{valid, packet}` to RS; registered.
- `replay_Iter` out ITER_W — current iteration index; registered.
- `busy` out 1 — high outside IDLE.
- `done` out 1 — one-cycle pulse when the last iteration retires.
- `err_underflow` out 1 — sticky; a completion arrived with zero outstanding.
- `stall_cycles` out 32 — present only with `DP_STALL_CNT_EN`.

## Operation
States:
- IDLE
  - `task_in_ready = (count < DEPTH)`. A handshake writes `buf[count]` and increments `count`.
  - On `start`: if `num_iter==0` or `count==0`, pulse `done` and stay in IDLE.
  - Otherwise latch `num_iter`, set `iter=0`, `ptr=0`, and go to SCAN.
- SCAN
  - Each cycle examine `buf[ptr]`.
  - If `buf[ptr][7+iter]` is 0: advance `ptr` with no issue.
  - If the mask bit is 1 and `RS_full` is low: issue the packet, increment `outstanding`, advance `ptr`.
  - If the mask bit is 1 and `RS_full` is high: hold `ptr` (stall).
  - When `ptr==count-1` has been consumed, go to WAIT.
- WAIT
  - Hold while `outstanding != 0`.
  - When `outstanding == 0`: if `iter==num_iter-1`, pulse `done`, clear `count`, and go to IDLE. Otherwise increment `iter`, set `ptr=0`, and go to SCAN.
- `outstanding` (width `$clog2(DEPTH+1)`) next value = current + issue − popcount(`pe_done`). The increment and decrements are applied in the same cycle.
- A decrement below 0 saturates at 0 and sets `err_underflow`. Only reset clears it.
- `task_in_ready` is 0 outside IDLE. The buffer contents persist across iterations.
- `start` is ignored when not in IDLE.
- `replay_Iter = iter`, held constant throughout SCAN and WAIT.

## Timing
- Reset values: `DP_task2RS_out=0`, `replay_Iter=0`, `busy=0`, `done=0`, `err_underflow=0`, `stall_cycles=0`, `task_in_ready=1`. Reset also sets `count=0`, `outstanding=0`, and state IDLE.
- Reset mid-operation abandons the run. The buffer is logically emptied and no further packets are issued from the next cycle on.
- Issue decisions sample `RS_full` in cycle t. `DP_task2RS_out.valid` is registered, so the packet appears in t+1.
  - `RS_full` already includes the RS write of the current cycle, so one issue per cycle is safe without a skid buffer.
- Throughput in SCAN is one buffer entry per cycle, whether or not it is issued.
- `start` to first possible `valid` is 2 cycles: IDLE→SCAN, then the registered output.
- Final `pe_done` (outstanding reaches 0) to `done` pulse is 1 cycle.
  - The next iteration's first `valid` follows 2 cycles after that final `pe_done`.
- A load and `start` in the same cycle: the load completes first and is included in the run.
- `task_in_valid` while `count==DEPTH`: not accepted (`ready=0`), packet dropped by the protocol.

## Configuration
- `DP_STALL_CNT_EN`
  - Defined: `stall_cycles` increments each SCAN cycle in which a matching packet is held by `RS_full`. It wraps at 2^32 and clears only on reset.
  - Undefined: the port and the counter are absent.

## Test plan
- Load 4 packets with mask 3'b001, `start` with `num_iter=1`, `RS_full=0`, and a PE pulse 3 cycles after each issue. Required: 4 consecutive `valid` cycles, `replay_Iter=0`, and `done` 1 cycle after the 4th `pe_done`.
- Load masks {001,010,110,100}, `num_iter=3`. Required: iter0 issues entry0; iter1 issues entries 1,2; iter2 issues entries 2,3. `replay_Iter` steps 0→1→2 only after each iteration's completions.
- Hold `RS_full=1` for 5 cycles during SCAN. Required: no `valid`, `ptr` held, and `stall_cycles=5` (with the macro defined). Issue resumes 1 cycle after `RS_full` falls.
- Issue and a 2-bit `pe_done` in the same cycle with `outstanding=3`. Required: `outstanding=2`. Then `pe_done` with `outstanding=0`. Required: `outstanding` stays 0 and `err_underflow=1`.
- `start` with `count=0`. Required: `done` pulse next cycle and no `valid`. Assert `reset` mid-SCAN. Required: next cycle all outputs are at their reset values and `task_in_ready=1`.
- Load `DEPTH`+1 packets. Required: `task_in_ready=0` after the 16th packet, and only 16 packets are issued on replay.

Source files
------------

// File: rtl/dp_task_dispatch_if.sv
// Load-side and RS-side signal bundle of the dispatch stage.
// master: the dispatch stage; slave: the load source / RS side driving it.
interface dp_task_dispatch_if #(
  parameter int unsigned PACKET_W = 32,
  parameter int unsigned ITER_W   = 2
);
  logic                task_in_valid;
  logic [PACKET_W-1:0] task_in_packet;
  logic                task_in_ready;
  logic                RS_full;
  logic [PACKET_W:0]   DP_task2RS_out;
  logic [ITER_W-1:0]   replay_Iter;

  modport master (
    input  task_in_valid, task_in_packet, RS_full,
    output task_in_ready, DP_task2RS_out, replay_Iter
  );

  modport slave (
    output task_in_valid, task_in_packet, RS_full,
    input  task_in_ready, DP_task2RS_out, replay_Iter
  );
endinterface

// File: rtl/dp_task_dispatch.sv
// Buffers edge-task packets, then replays them into the RS once per iteration, filtered by mask bits [9:7].
// Optional stall counter on stall_cycles when DP_STALL_CNT_EN is defined.
module dp_task_dispatch #(
  parameter int unsigned PACKET_W = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NUM_PE   = 4,
  parameter int unsigned ITER_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  dp_task_dispatch_if.master bus,
  input  logic               start,
  input  logic [ITER_W-1:0]  num_iter,
  input  logic [NUM_PE-1:0]  pe_done,
  output logic               busy,
  output logic               done,
  output logic               err_underflow
`ifdef DP_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PE_W     = $clog2(NUM_PE + 1);
  localparam int unsigned SUM_W    = ((CNT_W > PE_W) ? CNT_W : PE_W) + 1;
  localparam int unsigned MASK_LSB = 7;
  localparam int unsigned MASK_W   = 3;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [PACKET_W-1:0] buf_q [DEPTH];
  logic [CNT_W-1:0]    count_q, count_d, count_ld;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [ITER_W-1:0]   iter_q, iter_d, niter_q, niter_d;
  logic [CNT_W-1:0]    outst_q, outst_d;
  logic [PACKET_W:0]   out_q, out_d;
  logic                ready_q, busy_q, done_q, done_d, err_q, err_d;
  logic                load, hit, issue;
  logic [PACKET_W-1:0] cur_pkt;
  logic [MASK_W-1:0]   cur_mask;
  logic [SUM_W-1:0]    pe_cnt, sum;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, buffer walk and outstanding-task accounting
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ptr_d    = ptr_q;
    iter_d   = iter_q;
    niter_d  = niter_q;
    out_d    = '0;
    done_d   = 1'b0;
    err_d    = err_q;
    outst_d  = outst_q;
    load     = 1'b0;
    count_ld = count_q;
    cur_pkt  = buf_q[ptr_q];
    cur_mask = cur_pkt[MASK_LSB +: MASK_W];
    hit      = (state_q == S_SCAN) && cur_mask[iter_q];
    issue    = hit && !bus.RS_full;
    pe_cnt   = SUM_W'($countones(pe_done));
    sum      = SUM_W'(outst_q) + SUM_W'(issue);

    // Issue and completions land in the same cycle; never go below zero
    if (pe_cnt > sum) begin
      outst_d = '0;
      err_d   = 1'b1;
    end else begin
      outst_d = CNT_W'(sum - pe_cnt);
    end

    case (state_q)
      S_IDLE: begin
        load     = bus.task_in_valid && ready_q;
        count_ld = count_q + CNT_W'(load);
        count_d  = count_ld;
        // A load in the start cycle is part of the run
        if (start) begin
          if (num_iter == '0 || count_ld == '0) begin
            done_d = 1'b1;
          end else begin
            niter_d = num_iter;
            iter_d  = '0;
            ptr_d   = '0;
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (issue) out_d = {1'b1, cur_pkt};
        if (!(hit && bus.RS_full)) begin
          if (CNT_W'(ptr_q) == count_q - CNT_W'(1)) state_d = S_WAIT;
          else                                      ptr_d   = ptr_q + PTR_W'(1);
        end
      end
      S_WAIT: begin
        if (outst_d == '0) begin
          if (iter_q == niter_q - ITER_W'(1)) begin
            done_d  = 1'b1;
            count_d = '0;
            state_d = S_IDLE;
          end else begin
            iter_d  = iter_q + ITER_W'(1);
            ptr_d   = '0;
            state_d = S_SCAN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ptr_q   <= '0;
      iter_q  <= '0;
      niter_q <= '0;
      outst_q <= '0;
      out_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ptr_q   <= ptr_d;
      iter_q  <= iter_d;
      niter_q <= niter_d;
      outst_q <= outst_d;
      out_q   <= out_d;
      ready_q <= (state_d == S_IDLE) && (count_d < CNT_W'(DEPTH));
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Buffer contents are never reset; count alone defines what is valid
  always_ff @(posedge clk) begin
    if (load && !reset) buf_q[count_q[PTR_W-1:0]] <= bus.task_in_packet;
  end

`ifdef DP_STALL_CNT_EN
  logic        stall;
  logic [31:0] stall_q;

  assign stall = hit && bus.RS_full;

  always_ff @(posedge clk) begin
    if (reset)      stall_q <= '0;
    else if (stall) stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`endif

  assign bus.task_in_ready  = ready_q;
  assign bus.DP_task2RS_out = out_q;
  assign bus.replay_Iter    = iter_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err_underflow      = err_q;

endmodule
